addr_stack: RTL and testbench

ADDR_STACK -- requirements
Module: addr_stack

---
 rtl/addr_stack.sv | 183 ++++++++++++++++++
 tb/tb_addr_stack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : addr_stack
// Brief    : Program counter with a hardware return-address stack.
//            The FSM has two states. A command is accepted in IDLE and
//            committed one edge later in EXEC. WRAP selects circular or
//            blocking behaviour on stack overflow and underflow.
// Revision : 1.0  initial release
// ============================================================================
module addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int WRAP   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_op_i,
  input  logic [ADDR_W-1:0]          cmd_addr_i,
  input  logic                       clr_err_i,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic                       end_of_page_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DEP_W = $clog2(DEPTH+1);

  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [DEP_W-1:0] DEPTH_C = DEP_W'(DEPTH);

  localparam logic [2:0] OP_INCR = 3'd1;
  localparam logic [2:0] OP_JUMP = 3'd2;
  localparam logic [2:0] OP_PAGE = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_INTR = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DEP_W-1:0]   depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [ADDR_W-1:0]  mem_q [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_wdata;

  logic [ADDR_W-1:0]  pc_inc;
  logic [PTR_W-1:0]   ptr_inc;
  logic [PTR_W-1:0]   ptr_dec;
  logic               full;
  logic               empty;

  // Sequencing helpers. The pointer wraps explicitly so that a DEPTH that is
  // not a power of two still behaves modulo DEPTH.
  assign pc_inc  = pc_q + 1'b1;
  assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;
  assign full    = (depth_q == DEPTH_C);
  assign empty   = (depth_q == '0);

  // State register plus all architectural state. Reset aborts any command in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      pc_q    <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage has no reset. Writes happen only in EXEC, and reset forces
  // IDLE, so an aborted CALL cannot write to it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  // Next-state and command execution. An error flag raised on this edge takes
  // priority over clr_err.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    ptr_d       = ptr_q;
    depth_d     = depth_q;
    ovf_d       = ovf_q & ~clr_err_i;
    unf_d       = unf_q & ~clr_err_i;
    mem_we      = 1'b0;
    mem_wdata   = pc_inc;
    cmd_ready_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          state_d = S_EXEC;
          op_d    = cmd_op_i;
          addr_d  = cmd_addr_i;
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
        case (op_q)
          OP_INCR: pc_d = pc_inc;
          OP_JUMP: pc_d = addr_q;
          OP_PAGE: pc_d = {pc_inc[ADDR_W-1:8], addr_q[7:0]};
          OP_CALL, OP_INTR: begin
            // An interrupt returns to the interrupted instruction.
            // A call returns to the instruction after it.
            mem_wdata = (op_q == OP_INTR) ? pc_q : pc_inc;
            if (full) begin
              ovf_d = 1'b1;
            end
            if (!full || (WRAP != 0)) begin
              mem_we = 1'b1;
              ptr_d  = ptr_inc;
              pc_d   = addr_q;
              if (!full) begin
                depth_d = depth_q + 1'b1;
              end
            end
          end
          OP_RET: begin
            if (empty) begin
              unf_d = 1'b1;
            end
            if (!empty || (WRAP != 0)) begin
              ptr_d = ptr_dec;
              pc_d  = mem_q[ptr_dec];
              if (!empty) begin
                depth_d = depth_q - 1'b1;
              end
            end
          end
          default: ; // NOP and the reserved opcode leave state unchanged
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pc_o          = pc_q;
  assign depth_o       = depth_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;
  assign end_of_page_o = (pc_q[7:0] == 8'hFF);

endmodule
`default_nettype wire

// File: tb/tb_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_stack
// Brief    : Directed self-checking bench for addr_stack. Two instances run
//            side by side: one circular (WRAP=1) and one blocking (WRAP=0).
// Revision : 1.0  initial release
// ============================================================================
module tb_addr_stack;

  localparam int AW = 12;
  localparam int DP = 8;
  localparam int DW = $clog2(DP+1);

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] INCR = 3'd1;
  localparam logic [2:0] JUMP = 3'd2;
  localparam logic [2:0] PAGE = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;
  localparam logic [2:0] INTR = 3'd6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic          clr_err;

  logic          rdy_w, full_w, emp_w, ovf_w, unf_w, eop_w;
  logic [AW-1:0] pc_w;
  logic [DW-1:0] dep_w;
  logic          rdy_n, full_n, emp_n, ovf_n, unf_n, eop_n;
  logic [AW-1:0] pc_n;
  logic [DW-1:0] dep_n;

  logic          mid_rdy_w, mid_rdy_n;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  addr_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP(1)) u_dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy_w),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .clr_err_i(clr_err),
    .pc_o(pc_w), .depth_o(dep_w), .full_o(full_w), .empty_o(emp_w),
    .overflow_o(ovf_w), .underflow_o(unf_w), .end_of_page_o(eop_w)
  );

  addr_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP(0)) u_dut_block (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy_n),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .clr_err_i(clr_err),
    .pc_o(pc_n), .depth_o(dep_n), .full_o(full_n), .empty_o(emp_n),
    .overflow_o(ovf_n), .underflow_o(unf_n), .end_of_page_o(eop_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Returns at the negedge after the commit edge.
  task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] addr, input logic clr);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    clr_err   = clr;
    mid_rdy_w = rdy_w;
    mid_rdy_n = rdy_n;
    @(posedge clk);
    @(negedge clk);
    clr_err   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] exp_w, exp_n;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_addr  = '0;
    clr_err   = 1'b0;
    repeat (2) @(negedge clk);

    // State while reset is held
    check("rst_pc",    32'(pc_w),  32'h0);
    check("rst_depth", 32'(dep_w), 32'h0);
    check("rst_empty", 32'(emp_w), 32'h1);
    check("rst_full",  32'(full_w), 32'h0);
    check("rst_ovf",   32'(ovf_w), 32'h0);
    check("rst_unf",   32'(unf_w), 32'h0);
    check("rst_ready", 32'(rdy_w), 32'h1);
    rst_n = 1'b1;

    // Three INCRs, with the ready handshake checked for each
    for (int i = 0; i < 3; i++) begin
      check("incr_rdy_pre", 32'(rdy_w), 32'h1);
      do_cmd(INCR, '0, 1'b0);
      check("incr_rdy_exec", 32'(mid_rdy_w), 32'h0);
      check("incr_rdy_post", 32'(rdy_w), 32'h1);
      check("incr_pc", 32'(pc_w), 32'(i + 1));
    end
    check("incr_depth", 32'(dep_w), 32'h0);

    // INCR from all-ones wraps to zero
    do_cmd(JUMP, 12'hFFF, 1'b0);
    check("jump_pc", 32'(pc_n), 32'hFFF);
    do_cmd(INCR, '0, 1'b0);
    check("incr_wrap", 32'(pc_w), 32'h000);

    // PAGE issued at the end of a page lands in the next page
    do_cmd(JUMP, 12'h0FE, 1'b0);
    do_cmd(INCR, '0, 1'b0);
    check("eop_pc",  32'(pc_w),  32'h0FF);
    check("eop_flg", 32'(eop_w), 32'h1);
    do_cmd(PAGE, 12'h012, 1'b0);
    check("page_pc",  32'(pc_w),  32'h112);
    check("page_eop", 32'(eop_w), 32'h0);

    // CALL / INTR / RET / RET
    do_cmd(JUMP, 12'h010, 1'b0);
    do_cmd(CALL, 12'h300, 1'b0);
    check("call_pc", 32'(pc_w), 32'h300);
    check("call_dp", 32'(dep_w), 32'h1);
    do_cmd(INTR, 12'h400, 1'b0);
    check("intr_pc", 32'(pc_w), 32'h400);
    check("intr_dp", 32'(dep_w), 32'h2);
    do_cmd(RET, '0, 1'b0);
    check("ret1_pc", 32'(pc_w), 32'h300);
    check("ret1_dp", 32'(dep_w), 32'h1);
    do_cmd(RET, '0, 1'b0);
    check("ret2_pc", 32'(pc_w), 32'h011);
    check("ret2_dp", 32'(dep_w), 32'h0);
    check("ret2_empty", 32'(emp_w), 32'h1);

    // RET on an empty stack
    do_cmd(RET, '0, 1'b0);
    check("uf_flag_n", 32'(unf_n), 32'h1);
    check("uf_flag_w", 32'(unf_w), 32'h1);
    check("uf_pc_n",   32'(pc_n),  32'h011);
    check("uf_dp_w",   32'(dep_w), 32'h0);
    do_cmd(RET, '0, 1'b1);
    check("uf_vs_clr_n", 32'(unf_n), 32'h1);
    check("uf_vs_clr_w", 32'(unf_w), 32'h1);
    do_cmd(NOP, '0, 1'b1);
    check("clr_unf_n", 32'(unf_n), 32'h0);
    check("clr_unf_w", 32'(unf_w), 32'h0);
    check("clr_pc_n",  32'(pc_n),  32'h011);

    // Nine CALLs, then eight RETs
    pulse_reset();
    do_cmd(JUMP, 12'h100, 1'b0);
    for (int i = 0; i < 9; i++) begin
      do_cmd(CALL, 12'(12'h200 + 16 * i), 1'b0);
      check("ovf_dp_w", 32'(dep_w), 32'((i < 8) ? i + 1 : 8));
      check("ovf_dp_n", 32'(dep_n), 32'((i < 8) ? i + 1 : 8));
      if (i == 7) check("ovf_early", 32'(ovf_w), 32'h0);
    end
    check("ovf_w",    32'(ovf_w),  32'h1);
    check("ovf_n",    32'(ovf_n),  32'h1);
    check("ovf_full", 32'(full_w), 32'h1);
    check("ovf_pc_w", 32'(pc_w),   32'h280);
    check("ovf_pc_n", 32'(pc_n),   32'h270);
    for (int k = 0; k < 8; k++) begin
      do_cmd(RET, '0, 1'b0);
      exp_w = 12'(12'h271 - 16 * k);
      exp_n = (k < 7) ? 12'(12'h261 - 16 * k) : 12'h101;
      check("pop_pc_w", 32'(pc_w), 32'(exp_w));
      check("pop_pc_n", 32'(pc_n), 32'(exp_n));
    end
    check("pop_dp_w", 32'(dep_w), 32'h0);
    check("pop_dp_n", 32'(dep_n), 32'h0);

    // Reset asserted in the middle of a CALL's EXEC cycle
    cmd_valid = 1'b1;
    cmd_op    = CALL;
    cmd_addr  = 12'h555;
    @(posedge clk);
    #2 rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("mid_rst_pc",  32'(pc_w),  32'h0);
    check("mid_rst_dp",  32'(dep_w), 32'h0);
    check("mid_rst_ovf", 32'(ovf_w), 32'h0);
    check("mid_rst_unf", 32'(unf_w), 32'h0);
    check("mid_rst_rdy", 32'(rdy_w), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(INCR, '0, 1'b0);
    check("post_rst_pc", 32'(pc_w),  32'h1);
    check("post_rst_dp", 32'(dep_w), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
